dmem_arbiter: RTL and testbench

- Two-requester arbiter sharing the single-port data memory between the core load/store path (port C) and a DMA/debug loader (port D).
- Uses a valid/ready request handshake and returns registered read responses one cycle after acceptance.
- Arbitration is round-robin, with a bounded bus lock for D bursts and word-address range checking.
- Sits between the core/DMA and the data memory; it drives the memory's we/A/WD and samples its combinational RD.

---
 rtl/dmem_pkg.sv | 17 +
 rtl/dmem_rr_pick.sv | 21 ++
 rtl/dmem_arbiter.sv | 136 +++++++++++++
 tb/tb_dmem_arbiter.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and sizing constants for the data-memory arbiter slice.
package dmem_pkg;

  localparam int unsigned DMEM_DEPTH  = 1024;
  localparam int unsigned DMEM_DATA_W = 32;

  typedef enum logic {
    GNT_C = 1'b0,
    GNT_D = 1'b1
  } gnt_e;

  typedef enum logic {
    ARB   = 1'b0,
    LOCKD = 1'b1
  } arb_state_e;

endpackage

// File: rtl/dmem_rr_pick.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to whoever was not served last.
module dmem_rr_pick
  import dmem_pkg::*;
(
  input  logic [1:0] valid,
  input  gnt_e       last_gnt,
  output gnt_e       gnt
);

  // bit 0 is port C, bit 1 is port D
  always_comb begin
    gnt = GNT_C;
    case (valid)
      2'b01:   gnt = GNT_C;
      2'b10:   gnt = GNT_D;
      2'b11:   gnt = (last_gnt == GNT_C) ? GNT_D : GNT_C;
      default: gnt = GNT_C;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Core (C) / DMA (D) arbiter for the single-port data memory with D bus lock and range check.
// Define DMEM_ARB_PERF_EN to add saturating grant and conflict counters.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_W   = DMEM_DATA_W,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DEPTH    = DMEM_DEPTH,
  parameter int unsigned LOCK_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c_valid,
  output logic              c_ready,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  input  logic              d_valid,
  output logic              d_ready,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  input  logic              d_lock,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_a,
  output logic [DATA_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_rd,
  output logic              err
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [31:0]       c_grants,
  output logic [31:0]       d_grants,
  output logic [31:0]       conflicts
`endif
);

  localparam int unsigned       CntW     = $clog2(LOCK_MAX + 1);
  localparam logic [ADDR_W-1:0] DepthA   = ADDR_W'(DEPTH);
  localparam logic [CntW-1:0]   LockMaxC = CntW'(LOCK_MAX);

  arb_state_e        state;
  gnt_e              last_gnt;
  gnt_e              pick;
  logic [CntW-1:0]   lock_cnt;
  logic [1:0]        elig;
  logic              any_gnt;
  logic              acc;
  logic              sel_we;
  logic              in_range;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // Under lock C is masked out entirely, so it cannot win even while D is idle.
  assign elig = (state == LOCKD) ? {d_valid, 1'b0} : {d_valid, c_valid};

  dmem_rr_pick u_pick (
    .valid    (elig),
    .last_gnt (last_gnt),
    .gnt      (pick)
  );

  assign any_gnt   = |elig;
  assign c_ready   = any_gnt & (pick == GNT_C);
  assign d_ready   = any_gnt & (pick == GNT_D);
  assign acc       = c_ready | d_ready;
  assign sel_we    = d_ready ? d_we    : c_we;
  assign sel_addr  = d_ready ? d_addr  : c_addr;
  assign sel_wdata = d_ready ? d_wdata : c_wdata;
  assign in_range  = sel_addr < DepthA;

  assign mem_we = acc & sel_we & in_range;
  assign mem_a  = acc ? sel_addr  : '0;
  assign mem_wd = acc ? sel_wdata : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ARB;
      last_gnt <= GNT_C;
      lock_cnt <= '0;
      c_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      c_rdata  <= '0;
      d_rdata  <= '0;
      err      <= 1'b0;
    end else begin
      c_rvalid <= c_ready & ~c_we;
      d_rvalid <= d_ready & ~d_we;
      err      <= acc & ~in_range;
      if (c_ready && !c_we) c_rdata <= in_range ? mem_rd : '0;
      if (d_ready && !d_we) d_rdata <= in_range ? mem_rd : '0;
      if (acc) last_gnt <= d_ready ? GNT_D : GNT_C;

      case (state)
        ARB: begin
          if (d_ready && d_lock) begin
            state    <= LOCKD;
            lock_cnt <= CntW'(1);
          end
        end
        LOCKD: begin
          // last_gnt is already D on a forced exit, so C takes the next tie.
          if (!d_lock || (d_ready && (lock_cnt + 1'b1) == LockMaxC)) begin
            state    <= ARB;
            lock_cnt <= '0;
          end else if (d_ready) begin
            lock_cnt <= lock_cnt + 1'b1;
          end
        end
        default: begin
          state    <= ARB;
          lock_cnt <= '0;
        end
      endcase
    end
  end

`ifdef DMEM_ARB_PERF_EN
  // At most one port is accepted per cycle, so both valid always means one is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      c_grants  <= '0;
      d_grants  <= '0;
      conflicts <= '0;
    end else begin
      if (c_ready && c_grants != '1) c_grants <= c_grants + 32'd1;
      if (d_ready && d_grants != '1) d_grants <= d_grants + 32'd1;
      if (c_valid && d_valid && conflicts != '1) conflicts <= conflicts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus random traffic vs a reference model.
module tb_dmem_arbiter;
  localparam int unsigned DEPTH = 1024;
  localparam int          LMAX  = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        c_valid, c_ready, c_we, c_rvalid;
  logic [31:0] c_addr, c_wdata, c_rdata;
  logic        d_valid, d_ready, d_we, d_rvalid, d_lock;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        mem_we, err;
  logic [31:0] mem_a, mem_wd, mem_rd;
`ifdef DMEM_ARB_PERF_EN
  logic [31:0] c_grants, d_grants, conflicts;
`endif

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk(clk), .rst(rst),
    .c_valid(c_valid), .c_ready(c_ready), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .d_valid(d_valid), .d_ready(d_ready), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_lock(d_lock),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd), .err(err)
`ifdef DMEM_ARB_PERF_EN
    , .c_grants(c_grants), .d_grants(d_grants), .conflicts(conflicts)
`endif
  );

  // Memory seen by the DUT; out-of-range reads return junk the arbiter must mask.
  logic [31:0] phys [DEPTH];
  logic [31:0] refmem [DEPTH];
  logic        mem_init;

  function automatic logic [31:0] init_val(input int i);
    if (i == 28) return 32'd10;
    return (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_5A5A;
  endfunction

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < DEPTH; i++) phys[i] <= init_val(i);
    end else if (mem_we && mem_a < DEPTH) begin
      phys[mem_a[9:0]] <= mem_wd;
    end
  end
  assign mem_rd = (mem_a < DEPTH) ? phys[mem_a[9:0]] : 32'hBAD0_BAD0;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model state: who wins the next tie, whether D holds the bus and for how many beats.
  bit          m_prefer_d;
  bit          m_locked;
  int          m_beats;
  logic        e_crv, e_drv, e_err;
  logic [31:0] e_crd, e_drd;
  logic [31:0] m_cg, m_dg, m_cf;
  logic        s_cr, s_dr, s_mwe;

  task automatic model_reset();
    m_prefer_d = 1'b1; m_locked = 1'b0; m_beats = 0;
    e_crv = 1'b0; e_drv = 1'b0; e_err = 1'b0; e_crd = '0; e_drd = '0;
    m_cg = '0; m_dg = '0; m_cf = '0;
  endtask

  // Called just after a negedge with inputs already driven; returns at the next negedge.
  task automatic tick();
    int          win;
    logic [31:0] a, wd;
    logic        we, inr;
    #1;
    if (m_locked) win = d_valid ? 2 : 0;
    else if (c_valid && d_valid) win = m_prefer_d ? 2 : 1;
    else if (c_valid) win = 1;
    else if (d_valid) win = 2;
    else win = 0;
    a   = (win == 1) ? c_addr  : (win == 2) ? d_addr  : 32'd0;
    wd  = (win == 1) ? c_wdata : (win == 2) ? d_wdata : 32'd0;
    we  = (win == 1) ? c_we    : (win == 2) ? d_we    : 1'b0;
    inr = a < DEPTH;
    s_cr = c_ready; s_dr = d_ready; s_mwe = mem_we;
    chk("c_ready", 64'(c_ready), 64'(win == 1));
    chk("d_ready", 64'(d_ready), 64'(win == 2));
    chk("mem_we", 64'(mem_we), 64'(win != 0 && we && inr));
    chk("mem_a", 64'(mem_a), 64'(a));
    chk("mem_wd", 64'(mem_wd), 64'(wd));

    if (rst) begin
      model_reset();
    end else begin
      e_crv = (win == 1) && !we;
      e_drv = (win == 2) && !we;
      if (e_crv) e_crd = inr ? refmem[a[9:0]] : 32'd0;
      if (e_drv) e_drd = inr ? refmem[a[9:0]] : 32'd0;
      e_err = (win != 0) && !inr;
      if (win == 1) m_prefer_d = 1'b1;
      if (win == 2) m_prefer_d = 1'b0;
      if (m_locked) begin
        if (!d_lock) begin
          m_locked = 1'b0; m_beats = 0;
        end else if (win == 2) begin
          m_beats++;
          if (m_beats == LMAX) begin m_locked = 1'b0; m_beats = 0; end
        end
      end else if (win == 2 && d_lock) begin
        m_locked = 1'b1; m_beats = 1;
      end
      if (win == 1) m_cg++;
      if (win == 2) m_dg++;
      if (c_valid && d_valid) m_cf++;
    end
    if (win != 0 && we && inr) refmem[a[9:0]] = wd;

    @(posedge clk);
    #1;
    chk("c_rvalid", 64'(c_rvalid), 64'(e_crv));
    chk("d_rvalid", 64'(d_rvalid), 64'(e_drv));
    chk("c_rdata", 64'(c_rdata), 64'(e_crd));
    chk("d_rdata", 64'(d_rdata), 64'(e_drd));
    chk("err", 64'(err), 64'(e_err));
`ifdef DMEM_ARB_PERF_EN
    chk("c_grants", 64'(c_grants), 64'(m_cg));
    chk("d_grants", 64'(d_grants), 64'(m_dg));
    chk("conflicts", 64'(conflicts), 64'(m_cf));
`endif
    @(negedge clk);
  endtask

  task automatic idle();
    c_valid = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = '0;
    d_valid = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_lock = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned r = $urandom_range(0, 9);
    if (r < 7) return 32'($urandom_range(0, 15));
    if (r == 7) return 32'(1020 + $urandom_range(0, 7));
    if (r == 8) return $urandom;
    return 32'd1023;
  endfunction

  initial begin
    int dbeats;
    int before_c;
    mem_init = 1'b1;
    rst = 1'b1;
    idle();
    for (int i = 0; i < DEPTH; i++) refmem[i] = init_val(i);
    model_reset();
    @(negedge clk);
    mem_init = 1'b0;

    // Reset values
    do_reset();
    chk("rst_c_rvalid", 64'(c_rvalid), 64'd0);
    chk("rst_d_rvalid", 64'(d_rvalid), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_c_rdata", 64'(c_rdata), 64'd0);
    chk("rst_d_rdata", 64'(d_rdata), 64'd0);

    // Single C read of addr 28
    c_valid = 1'b1; c_addr = 32'd28;
    tick();
    chk("s1_c_ready", 64'(s_cr), 64'd1);
    chk("s1_c_rvalid", 64'(c_rvalid), 64'd1);
    chk("s1_c_rdata", 64'(c_rdata), 64'd10);
    chk("s1_d_rvalid", 64'(d_rvalid), 64'd0);
    idle();

    // Conflicting reads alternate D,C,D,C,D,C
    do_reset();
    c_valid = 1'b1; c_addr = 32'd100; d_valid = 1'b1; d_addr = 32'd200;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("s2_grant_d", 64'(s_dr), 64'(i % 2 == 0));
      chk("s2_d_rvalid", 64'(d_rvalid), 64'(i % 2 == 0));
      chk("s2_c_rvalid", 64'(c_rvalid), 64'(i % 2 == 1));
    end
`ifdef DMEM_ARB_PERF_EN
    chk("s2_c_grants", 64'(c_grants), 64'd3);
    chk("s2_d_grants", 64'(d_grants), 64'd3);
    chk("s2_conflicts", 64'(conflicts), 64'd6);
`endif
    idle();

    // Locked D burst: C must wait exactly LOCK_MAX beats
    d_valid = 1'b1; d_we = 1'b1; d_addr = 32'd5; d_wdata = 32'hDEAD_BEEF; d_lock = 1'b1;
    c_valid = 1'b1; c_addr = 32'd5;
    dbeats = 0; before_c = -1;
    for (int i = 0; i < 16 && (dbeats < 10 || c_valid); i++) begin
      tick();
      if (s_dr) dbeats++;
      if (s_cr) begin
        before_c = dbeats;
        chk("s3_c_rvalid", 64'(c_rvalid), 64'd1);
        chk("s3_c_rdata", 64'(c_rdata), 64'hDEAD_BEEF);
        c_valid = 1'b0;
      end
      if (dbeats == 10) begin d_valid = 1'b0; d_lock = 1'b0; end
    end
    chk("s3_beats_before_c", 64'(before_c), 64'd8);
    chk("s3_d_beats", 64'(dbeats), 64'd10);
    idle();
    tick();

    // Out-of-range write then read
    c_valid = 1'b1; c_we = 1'b1; c_addr = 32'd1024; c_wdata = 32'h1234_5678;
    tick();
    chk("s4_wr_mem_we", 64'(s_mwe), 64'd0);
    chk("s4_wr_err", 64'(err), 64'd1);
    c_we = 1'b0;
    tick();
    chk("s4_rd_mem_we", 64'(s_mwe), 64'd0);
    chk("s4_rd_err", 64'(err), 64'd1);
    chk("s4_rd_rvalid", 64'(c_rvalid), 64'd1);
    chk("s4_rd_rdata", 64'(c_rdata), 64'd0);
    idle();
    tick();
    chk("s4_err_pulse", 64'(err), 64'd0);

    // Reset while locked and with a D read accepted in the reset cycle
    d_valid = 1'b1; d_we = 1'b1; d_addr = 32'd7; d_wdata = 32'h0000_0077; d_lock = 1'b1;
    tick();
    d_we = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("s5_d_rvalid", 64'(d_rvalid), 64'd0);
    idle();
    c_valid = 1'b1; c_addr = 32'd3;
    tick();
    chk("s5_lock_dropped", 64'(s_cr), 64'd1);
    idle();
    d_valid = 1'b1; d_addr = 32'd4;
    tick();
    do_reset();
    c_valid = 1'b1; c_addr = 32'd8; d_valid = 1'b1; d_addr = 32'd9;
    tick();
    chk("s5_conflict_to_d", 64'(s_dr), 64'd1);
    idle();
    tick();

    // Random traffic; a stalled requester usually holds its request
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 299) == 0);
      if (!(c_valid && !s_cr && $urandom_range(0, 9) != 0)) begin
        c_valid = ($urandom_range(0, 9) < 6);
        c_we    = 1'($urandom_range(0, 1));
        c_addr  = rand_addr();
        c_wdata = $urandom;
      end
      if (!(d_valid && !s_dr && $urandom_range(0, 9) != 0)) begin
        d_valid = ($urandom_range(0, 9) < 6);
        d_we    = 1'($urandom_range(0, 1));
        d_addr  = rand_addr();
        d_wdata = $urandom;
      end
      d_lock = ($urandom_range(0, 9) < 7);
      tick();
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
